parking_lot_ctrl: RTL
=====================

# parking_lot_ctrl

Parking-lot occupancy controller. It watches two gate photo-sensors, decodes complete car entries and exits with a sensor-sequence FSM, and keeps a saturating occupancy count. The 5-bit count drives the hex display decoder, which renders CLEAR, 1–24 or FULL. The block owns the only counter the display reads; all count changes go through it.

## Interface

- `CAPACITY`, default 25: maximum occupancy. Legal range 1–31.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `a` input 1: outer sensor, raw and asynchronous; 1 = beam blocked.
- `b` input 1: inner sensor, raw and asynchronous; 1 = beam blocked.
- `count` output 5: current occupancy, 0..CAPACITY; feeds the hex display decoder.
- `enter_pulse` output 1: one-cycle pulse on each completed entry, including a refused entry.
- `exit_pulse` output 1: one-cycle pulse on each completed exit, including a refused exit.
- `full` output 1: high when `count == CAPACITY`.
- `empty` output 1: high when `count == 0`.
- `err_pulse` output 1: one-cycle pulse when an entry arrives at full or an exit arrives at empty.

## Operation

- **Synchronizer.**
  - `a` and `b` each pass through a 2-flop synchronizer to give `a_s` and `b_s`.
  - The FSM uses only `s = {a_s, b_s}`.
- **FSM states:** IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
- **From IDLE:**
  - s=10 → EN1.
  - s=01 → EX1.
  - s=00 or 11 → stay in IDLE. 11 from IDLE is an illegal start and is ignored.
- **EN1:**
  - 11 → EN2.
  - 10 → stay.
  - 00 or 01 → IDLE. The car backed out or the input glitched; no count change.
- **EN2:**
  - 01 → EN3.
  - 10 → EN1.
  - 11 → stay.
  - 00 → IDLE, no count change.
- **EN3:**
  - 00 → IDLE and an entry event is generated.
  - 11 → EN2.
  - 01 → stay.
  - 10 → IDLE, no count change.
- **EX1/EX2/EX3:** mirror images of EN1/EN2/EN3 with `a` and `b` swapped (01 → 11 → 10 → 00). The final 00 from EX3 generates an exit event.
- **Entry event:**
  - If `count < CAPACITY`: count+1 and `enter_pulse` = 1.
  - Otherwise: count holds, `enter_pulse` = 1 and `err_pulse` = 1.
- **Exit event:**
  - If `count > 0`: count−1 and `exit_pulse` = 1.
  - Otherwise: count holds, `exit_pulse` = 1 and `err_pulse` = 1.
- **Event exclusivity.** Only one car can be in the gate at a time, so entry and exit events are mutually exclusive by construction. No simultaneous increment/decrement path exists.
- **Arithmetic.**
  - `count` is 5-bit unsigned and never wraps.
  - Saturation limits are 0 and CAPACITY.
  - `full` and `empty` are combinational decodes of the `count` register.
- **Reset values.**
  - While `reset_n` = 0: synchronizer flops = 0, state = IDLE, `count` = 0.
  - `enter_pulse`, `exit_pulse` and `err_pulse` = 0.
  - `empty` = 1; `full` = 0 (for CAPACITY ≥ 1).
- **Reset mid-sequence.** Any partial entry or exit in progress is discarded. The first event after release requires a complete four-step sequence starting from IDLE.

## Timing

- **Synchronizer delay.**
  - A raw sensor value sampled at edge N appears on `a_s`/`b_s` after edge N+1.
  - The FSM acts on it at edge N+2.
- **Event latency.**
  - Raw s=00 is sampled at edge N while the FSM is in EN3 or EX3.
  - At edge N+2, `count`, `enter_pulse`/`exit_pulse`, `err_pulse` and the state all update together.
  - The pulses are high for exactly the one cycle after edge N+2, then return to 0 at edge N+3 unless a new event fires.
  - `full`/`empty` reflect the new `count` in the same cycle the pulse is high.
- **Glitch filtering.** Each sensor level must persist for at least one clock at `a_s`/`b_s` to be seen. Shorter pulses may be missed; this is acceptable.
- **Reset release.** `reset_n` is asserted asynchronously and released synchronously by the system reset generator. The first FSM transition occurs no earlier than 2 edges after release.

## Test plan

- **Reset.** Hold `reset_n` = 0 with a=b=1 → `count` = 0, `empty` = 1, all pulses 0, state IDLE. After release, hold a=b=1 for 10 cycles → `count` stays 0.
- **Single entry.** Apply ab sequence 00, 10, 11, 01, 00, each level held 4 cycles → `enter_pulse` high for exactly 1 cycle, 2 edges after the final 00 is sampled; `count` 0→1, `empty` falls in the same cycle.
- **Aborted entry.** Apply 10, 11, 10, 00 (backs out), then 01, 00 → no pulses; `count` unchanged.
- **Fill past capacity.** Apply 26 complete entries → `count` reaches 25 with `full` = 1 on the 25th. The 26th gives `enter_pulse` = 1, `err_pulse` = 1, `count` stays 25. Then one exit (01, 11, 10, 00) → `count` = 24, `full` = 0.
- **Exit at empty.** After reset, apply a complete exit sequence → `exit_pulse` = 1, `err_pulse` = 1, `count` stays 0, `empty` stays 1.
- **Reset mid-sequence.** Reach EN3 (10, 11, 01), pulse `reset_n` low for 1 cycle while s=01, then apply 00 → no pulse; `count` = 0. A following full entry → `count` = 1.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: synchronizes two gate sensors, decodes
// complete entry/exit sequences and keeps a saturating occupancy count.
module parking_lot_ctrl #(
  parameter int unsigned CAPACITY = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a,
  input  logic       b,
  output logic [4:0] count,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       full,
  output logic       empty,
  output logic       err_pulse
);

  localparam logic [4:0] CAP = 5'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  logic [1:0] a_sync_r;
  logic [1:0] b_sync_r;
  logic [1:0] s;
  state_t     state_r;
  state_t     state_next_s;
  logic       entry_evt_s;
  logic       exit_evt_s;
  logic [4:0] count_next_s;
  logic       enter_next_s;
  logic       exit_next_s;
  logic       err_next_s;

  // Two-flop synchronizers for the raw sensor inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync_r <= 2'b00;
      b_sync_r <= 2'b00;
    end else begin
      a_sync_r <= {a_sync_r[0], a};
      b_sync_r <= {b_sync_r[0], b};
    end
  end

  assign s = {a_sync_r[1], b_sync_r[1]};

  // Sequence decoder: entries walk 10-11-01-00, exits walk 01-11-10-00.
  always_comb begin
    state_next_s = state_r;
    entry_evt_s  = 1'b0;
    exit_evt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        case (s)
          2'b10:   state_next_s = EN1;
          2'b01:   state_next_s = EX1;
          default: state_next_s = IDLE;
        endcase
      end
      EN1: begin
        case (s)
          2'b11:   state_next_s = EN2;
          2'b10:   state_next_s = EN1;
          default: state_next_s = IDLE;
        endcase
      end
      EN2: begin
        case (s)
          2'b01:   state_next_s = EN3;
          2'b10:   state_next_s = EN1;
          2'b11:   state_next_s = EN2;
          default: state_next_s = IDLE;
        endcase
      end
      EN3: begin
        case (s)
          2'b00: begin
            state_next_s = IDLE;
            entry_evt_s  = 1'b1;
          end
          2'b11:   state_next_s = EN2;
          2'b01:   state_next_s = EN3;
          default: state_next_s = IDLE;
        endcase
      end
      EX1: begin
        case (s)
          2'b11:   state_next_s = EX2;
          2'b01:   state_next_s = EX1;
          default: state_next_s = IDLE;
        endcase
      end
      EX2: begin
        case (s)
          2'b10:   state_next_s = EX3;
          2'b01:   state_next_s = EX1;
          2'b11:   state_next_s = EX2;
          default: state_next_s = IDLE;
        endcase
      end
      EX3: begin
        case (s)
          2'b00: begin
            state_next_s = IDLE;
            exit_evt_s   = 1'b1;
          end
          2'b11:   state_next_s = EX2;
          2'b10:   state_next_s = EX3;
          default: state_next_s = IDLE;
        endcase
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Saturating count update; refused events still pulse, plus err.
  always_comb begin
    count_next_s = count;
    enter_next_s = 1'b0;
    exit_next_s  = 1'b0;
    err_next_s   = 1'b0;
    if (entry_evt_s) begin
      enter_next_s = 1'b1;
      if (count < CAP) begin
        count_next_s = count + 5'd1;
      end else begin
        err_next_s = 1'b1;
      end
    end else if (exit_evt_s) begin
      exit_next_s = 1'b1;
      if (count > 5'd0) begin
        count_next_s = count - 5'd1;
      end else begin
        err_next_s = 1'b1;
      end
    end else begin
      count_next_s = count;
    end
  end

  // State, count and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count       <= 5'd0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count       <= count_next_s;
      enter_pulse <= enter_next_s;
      exit_pulse  <= exit_next_s;
      err_pulse   <= err_next_s;
    end
  end

  assign full  = (count == CAP);
  assign empty = (count == 5'd0);

endmodule
